// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: serial input plus word-assembly outputs of uart_word_rx
interface uart_word_rx_if #(
    parameter int NUM_BYTES = 4
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;

    logic          rx;
    logic [W-1:0]  word;
    logic          word_valid;
    logic          frame_err;
    logic          timeout_err;
    logic          parity_err;
    logic [IW-1:0] byte_idx;
    logic          busy;

    modport master (
        output rx,
        input  word, word_valid, frame_err, timeout_err, parity_err, byte_idx, busy
    );

    modport slave (
        input  rx,
        output word, word_valid, frame_err, timeout_err, parity_err, byte_idx, busy
    );
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver assembling NUM_BYTES frames (MSB byte first) into one word; even parity with UART_WORD_RX_PARITY_EN
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 521,
    parameter int NUM_BYTES    = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input logic           clk,
    input logic           rst,
    uart_word_rx_if.slave bus
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [CW-1:0] C_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_WORD_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic [W-1:0]  asm_q, asm_next, word_q;
    logic [IW-1:0] idx_q;
    logic          valid_q, ferr_q, terr_q;

    // Each accepted byte shifts in at the bottom, so the first byte ends up on top
    assign asm_next = (asm_q << 8) | W'(sh);

`ifdef UART_WORD_RX_PARITY_EN
    logic par_bit, perr_q, par_bad;
    assign par_bad        = ^sh ^ par_bit;
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.word        = word_q;
    assign bus.word_valid  = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.timeout_err = terr_q;
    assign bus.byte_idx    = idx_q;
    assign bus.busy        = (state != IDLE) || (idx_q != '0);

    // Two-flop synchronizer on the asynchronous rx pin, idling high
    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_m, rx_s} <= 2'b11;
        else     {rx_m, rx_s} <= {bus.rx, rx_m};

    // Frame FSM: start validation, bit sampling, word assembly and inter-byte timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            cnt     <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                        tcnt  <= '0;
                    end else if (idx_q == '0) begin
                        tcnt <= '0;
                    end else if (tcnt == T_LAST) begin
                        idx_q  <= '0;
                        terr_q <= 1'b1;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                START: if (cnt == C_MID) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : DATA;
                end
                DATA: if (cnt == C_LAST) begin
                    cnt     <= '0;
                    sh      <= {rx_s, sh[7:1]};
                    bit_idx <= bit_idx + 1'b1;
`ifdef UART_WORD_RX_PARITY_EN
                    if (bit_idx == 3'd7) state <= PARITY;
`else
                    if (bit_idx == 3'd7) state <= STOP;
`endif
                end
`ifdef UART_WORD_RX_PARITY_EN
                PARITY: if (cnt == C_LAST) begin
                    cnt     <= '0;
                    par_bit <= rx_s;
                    state   <= STOP;
                end
`endif
                STOP: if (cnt == C_LAST) begin
                    cnt <= '0;
                    if (!rx_s) begin
                        ferr_q <= 1'b1;
                        idx_q  <= '0;
                        state  <= BREAK;
`ifdef UART_WORD_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_q <= 1'b1;
                        idx_q  <= '0;
                        state  <= IDLE;
`endif
                    end else if (idx_q == I_LAST) begin
                        word_q  <= asm_next;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        state   <= IDLE;
                    end else begin
                        asm_q <= asm_next;
                        idx_q <= idx_q + 1'b1;
                        state <= IDLE;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: randomized and directed checks of uart_word_rx against a byte-level reference model
module tb_uart_word_rx;
    localparam int CPB = 16;
    localparam int NB  = 4;
    localparam int TOB = 20;
    localparam int W   = 8 * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_word_rx_if #(.NUM_BYTES(NB)) bus ();

    uart_word_rx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   held[$];
    logic [W-1:0] exp_words[$];
    logic [W-1:0] got_words[$];
    logic [W-1:0] exp_word = '0;
    int exp_frame = 0, exp_tmo = 0, exp_par = 0;
    int n_frame = 0, n_tmo = 0, n_par = 0;
    int cyc = 0, idx_cyc = 0, tmo_delay = -1, pulses = 0;
    logic [1:0] prev_idx = '0;
`ifdef UART_WORD_RX_PARITY_EN
    bit flip_par = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe pulses away from the active edge and log completed words
    always @(negedge clk) begin
        cyc++;
        if (bus.timeout_err) begin
            n_tmo++;
            tmo_delay = cyc - idx_cyc;
        end
        if (bus.byte_idx != prev_idx) idx_cyc = cyc;
        prev_idx = bus.byte_idx;
        if (bus.word_valid) got_words.push_back(bus.word);
        if (bus.frame_err) n_frame++;
        if (bus.parity_err) n_par++;
        pulses = int'(bus.word_valid) + int'(bus.frame_err) + int'(bus.timeout_err) + int'(bus.parity_err);
        if (pulses != 0) check("pulse_exclusive", pulses, 1);
    end

    task automatic model_byte(input logic [7:0] d, input bit ok);
        logic [W-1:0] w;
        if (!ok) begin
            exp_frame++;
            held.delete();
            return;
        end
        held.push_back(d);
        if (held.size() == NB) begin
            w = '0;
            foreach (held[i]) w = (w << 8) | W'(held[i]);
            exp_words.push_back(w);
            exp_word = w;
            held.delete();
        end
    endtask

    task automatic model_idle_long();
        if (held.size() != 0) exp_tmo++;
        held.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit);
        bus.rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_WORD_RX_PARITY_EN
        bus.rx = ^d ^ flip_par;
        repeat (CPB) @(posedge clk);
`endif
        bus.rx = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit ok);
        send_frame(d, ok);
        model_byte(d, ok);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".nwords"}, got_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
            check({tag, ".word_seq"}, got_words[i], exp_words[i]);
        check({tag, ".frame_errs"}, n_frame, exp_frame);
        check({tag, ".timeouts"}, n_tmo, exp_tmo);
        check({tag, ".parity_errs"}, n_par, exp_par);
        check({tag, ".byte_idx"}, bus.byte_idx, held.size());
        check({tag, ".word"}, bus.word, exp_word);
        got_words.delete();
        exp_words.delete();
    endtask

    task automatic send_word(input logic [W-1:0] w, input string tag);
        for (int i = NB - 1; i >= 0; i--) begin
            send_byte(w[8*i +: 8], 1'b1);
            #1 check({tag, ".idx_step"}, bus.byte_idx, held.size());
        end
        check_state(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bit ok;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.word", bus.word, 0);
        check("rst.word_valid", bus.word_valid, 0);
        check("rst.frame_err", bus.frame_err, 0);
        check("rst.timeout_err", bus.timeout_err, 0);
        check("rst.parity_err", bus.parity_err, 0);
        check("rst.byte_idx", bus.byte_idx, 0);
        check("rst.busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;
        idle(2 * CPB);

        send_word(32'h12345678, "valid");

        send_byte(8'h11, 1'b1);
        send_byte(8'hAA, 1'b0);
        repeat (5 * CPB) @(posedge clk);
        idle(2 * CPB);
        check_state("frame_err");
        send_word(32'hCAFEF00D, "frame_after");

        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        #1 check("tmo.idx_before", bus.byte_idx, held.size());
        idle(25 * CPB);
        model_idle_long();
        check("tmo.delay", tmo_delay, TOB * CPB);
        check_state("timeout");
        send_word(32'h0BADC0DE, "tmo_after");

        send_byte(8'h5C, 1'b1);
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        idle(2 * CPB);
        check_state("glitch");
        for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
        check_state("glitch_after");

        send_byte(8'h77, 1'b1);
        send_byte(8'h66, 1'b1);
        bus.rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0];
            repeat (CPB) @(posedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst.word", bus.word, 0);
        check("midrst.word_valid", bus.word_valid, 0);
        check("midrst.byte_idx", bus.byte_idx, 0);
        check("midrst.busy", bus.busy, 0);
        check("midrst.errs", {bus.frame_err, bus.timeout_err, bus.parity_err}, 0);
        held.delete();
        exp_word = '0;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        idle(2 * CPB);
        send_word(32'hDEADBEEF, "rst_after");

`ifdef UART_WORD_RX_PARITY_EN
        flip_par = 1'b1;
        send_frame(8'h01, 1'b1);
        flip_par = 1'b0;
        exp_par++;
        held.delete();
        idle(2);
        send_byte(8'h03, 1'b1);
        check_state("parity");
        for (int i = 0; i < 3; i++) send_byte(8'hF0 + 8'(i), 1'b1);
        check_state("parity_after");
`endif

        for (int it = 0; it < 40; it++) begin
            d  = 8'($urandom);
            ok = $urandom_range(0, 7) != 0;
            send_byte(d, ok);
            idle(ok ? int'($urandom_range(0, 3 * CPB)) : int'($urandom_range(3, 3 * CPB)));
            if ($urandom_range(0, 9) == 0) begin
                idle(25 * CPB);
                model_idle_long();
            end
            if (it % 10 == 9) check_state("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
